// File: rtl/feature_frame_loader.sv
// feature_frame_loader
//
// Producer side of the drowsiness detector's feature interface. Samples arrive
// one at a time over a valid/ready handshake. They are packed into an
// N_FEAT-entry frame, and the frame is handed to the detector with a one-cycle
// start pulse. The frame then stays frozen until the detector reports done or
// the watchdog expires.
//
// Ports:
//   Clock        system clock, rising edge
//   Rst          asynchronous active-low reset
//   in_valid     sample present on in_data
//   in_data      W-bit feature sample
//   in_last      current sample closes the frame
//   in_ready     loader accepts a sample this cycle (registered)
//   det_done     detector finished the current frame (level or pulse)
//   frame_out    assembled frame, sample k at [k*W +: W]
//   det_start    one-cycle start pulse to the detector
//   frame_err    one-cycle pulse, frame length mismatch
//   timeout_err  one-cycle pulse, detector did not finish in time
//   frame_cnt    frames launched, modulo 256
//   fill_cnt     samples held in the current partial frame
module feature_frame_loader #(
  parameter int N_FEAT  = 30,
  parameter int W       = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic                          Clock,
  input  logic                          Rst,
  input  logic                          in_valid,
  input  logic [W-1:0]                  in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  input  logic                          det_done,
  output logic [N_FEAT*W-1:0]           frame_out,
  output logic                          det_start,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic [7:0]                    frame_cnt,
  output logic [$clog2(N_FEAT+1)-1:0]   fill_cnt
);

  localparam int FILL_W = $clog2(N_FEAT + 1);
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [FILL_W-1:0] LAST_SLOT = FILL_W'(N_FEAT - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FILL,
    DROP,
    START,
    WAIT_DONE
  } state_t;

  state_t            state;
  logic [WD_W-1:0]   watchdog;
  logic              accept;

  assign accept = in_valid & in_ready;

  // Single registered FSM. in_ready is registered as a decode of the next
  // state, so it is 1 in FILL/DROP and 0 in START/WAIT_DONE. Because it
  // defaults to 1 here, it rises on the first edge after reset release.
  // The error and start pulses default low, so each pulse lasts exactly one
  // cycle.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state       <= FILL;
      watchdog    <= '0;
      frame_out   <= '0;
      fill_cnt    <= '0;
      frame_cnt   <= '0;
      det_start   <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      det_start   <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      in_ready    <= 1'b1;

      case (state)
        FILL: begin
          if (accept) begin
            for (int k = 0; k < N_FEAT; k++) begin
              if (fill_cnt == FILL_W'(k)) begin
                frame_out[k*W +: W] <= in_data;
              end
            end
            // The count is cleared on every exit from the slot-(N_FEAT-1)
            // position, so a stored fill_cnt never reaches N_FEAT.
            if (fill_cnt == LAST_SLOT) begin
              fill_cnt <= '0;
              if (in_last) begin
                state     <= START;
                in_ready  <= 1'b0;
                det_start <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
              end else begin
                frame_err <= 1'b1;
                state     <= DROP;
              end
            end else if (in_last) begin
              frame_err <= 1'b1;
              fill_cnt  <= '0;
            end else begin
              fill_cnt <= fill_cnt + FILL_W'(1);
            end
          end
        end

        // Swallow the tail of an overlong frame up to its closing sample.
        DROP: begin
          if (accept && in_last) begin
            state <= FILL;
          end
        end

        // det_done is deliberately not looked at here.
        START: begin
          state    <= WAIT_DONE;
          watchdog <= '0;
          in_ready <= 1'b0;
        end

        // When done and the watchdog limit arrive together, done is checked
        // first, so no timeout pulse is raised.
        WAIT_DONE: begin
          if (det_done) begin
            state    <= FILL;
            fill_cnt <= '0;
            watchdog <= '0;
          end else if (watchdog == WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= FILL;
            fill_cnt    <= '0;
            watchdog    <= '0;
          end else begin
            watchdog <= watchdog + WD_W'(1);
            in_ready <= 1'b0;
          end
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: doc/feature_frame_loader.md
# feature_frame_loader

Producer side of the detector's feature interface. It accepts a stream of 10-bit feature samples over a valid/ready handshake and assembles them into a 30-entry frame. It presents the frame as a flat bus to `DrowsinessDetector`, issues a one-cycle start pulse, and holds the frame stable until the detector reports done. It replaces the switch-driven constant feature vectors in the board top level.

## Interface
- `N_FEAT`, 30, samples per frame.
- `W`, 10, bits per sample.
- `TIMEOUT`, 4096, max cycles in WAIT_DONE before abort.
- `Clock`  in  1  system clock, all logic rising-edge.
- `Rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  sample present on `in_data`.
- `in_data`  in  W  feature sample.
- `in_last`  in  1  qualifies the current sample as the final sample of a frame.
- `in_ready`  out  1  loader accepts a sample this cycle.
- `det_done`  in  1  detector finished the current frame; level or pulse.
- `frame_out`  out  N_FEAT*W  assembled frame; sample k at bits [k*W +: W].
- `det_start`  out  1  one-cycle start pulse to detector.
- `frame_err`  out  1  one-cycle pulse: frame length mismatch.
- `timeout_err`  out  1  one-cycle pulse: detector did not finish in time.
- `frame_cnt`  out  8  frames launched, wraps 255→0.
- `fill_cnt`  out  5  samples held in the current partial frame.

## Operation
- Reset (`Rst`=0, async) values:
  - FSM = FILL.
  - `frame_out` = 0, `fill_cnt` = 0, `frame_cnt` = 0.
  - `det_start` = 0, `frame_err` = 0, `timeout_err` = 0.
  - `in_ready` = 0 while `Rst` is low. It reads 1 from the first edge after release.
- Accept = `in_valid & in_ready`. `in_ready` = 1 in FILL and DROP, 0 in START and WAIT_DONE.
- FILL:
  - On accept, write `in_data` into slot `fill_cnt` of `frame_out` and increment `fill_cnt`.
  - If `fill_cnt`==N_FEAT-1 and `in_last`=1: frame complete, go to START.
  - If `in_last`=1 at any other count (early last): pulse `frame_err`, clear `fill_cnt`, stay in FILL. The partial data stays in `frame_out` but is overwritten by the next frame.
  - If `fill_cnt`==N_FEAT-1 and `in_last`=0 (overlong frame): pulse `frame_err`, clear `fill_cnt`, go to DROP.
- DROP: discard accepted samples. On an accepted sample with `in_last`=1, go to FILL. No error pulse on exit.
- START: `det_start`=1 for exactly this cycle; `frame_cnt` increments. Next state is WAIT_DONE. `det_done` is ignored in this cycle.
- WAIT_DONE:
  - `frame_out` is frozen.
  - A watchdog counter counts cycles from entry.
  - `det_done`=1: clear `fill_cnt` and the watchdog, go to FILL.
  - Watchdog reaches TIMEOUT-1 without done: pulse `timeout_err`, go to FILL, `fill_cnt`=0.
  - If done and timeout land on the same cycle, done wins and there is no error pulse.
- Width rules:
  - `fill_cnt` is clog2(N_FEAT+1) bits, 5 for the defaults, and never exceeds N_FEAT-1 in a stored state.
  - The watchdog is clog2(TIMEOUT) bits.
  - `frame_cnt` is modulo 256.
- Async reset mid-frame or mid-wait aborts immediately to the reset values. No start pulse is emitted on the reset-release edge.

## Timing
- `in_ready` is a registered state decode, not combinational from `in_valid`.
- The last sample is accepted on edge E. FSM=START after E, `det_start` is high between E and E+1, and WAIT_DONE begins at E+1.
- Sample-to-start latency: 1 cycle after the final accept.
- `det_done` sampled high at edge D leaves `in_ready`=1 after D. A new first sample can be accepted at D+1.
- Minimum frame period: N_FEAT accept cycles, plus 1 START cycle, plus detector latency, plus 1.
- `frame_err` and `timeout_err` are high for the one cycle after the offending edge.
- `frame_out` updates only on accepts in FILL.

## Test plan
- **Nominal frame.** After reset, stream 30 samples of value 200 (`in_last` on #30), `in_valid` held high. Expect:
  - `det_start` pulses exactly once, one cycle after the 30th accept.
  - Every `frame_out` slot reads 200.
  - `frame_cnt`=1 and `in_ready`=0 until `det_done`.
- **Back-pressure and gaps.** Random `in_valid` gaps with sample k = k. Expect slot k = k, and no accepts while in START or WAIT_DONE even with `in_valid`=1.
- **Early last.** `in_last` on sample 12. Expect:
  - `frame_err` pulses once, `fill_cnt`=0, no `det_start`.
  - A following clean 30-sample frame launches normally.
- **Overlong frame.** 35 samples with `in_last` on #35. Expect:
  - `frame_err` after #30, and samples 31–35 are dropped.
  - A subsequent 30-sample frame produces one `det_start`.
- **Timeout and done/timeout collision.** Set TIMEOUT=16.
  - `det_done` never asserts: expect `timeout_err` 16 cycles after entering WAIT_DONE, with FSM back in FILL.
  - `det_done` asserted on the 16th cycle: expect no `timeout_err`.
- **Reset and wrap.** Drop `Rst` mid-frame after 17 samples: expect all outputs at reset values immediately, asynchronously. Launch 256 frames: expect `frame_cnt` wraps to 0.
